// File: rtl/core_db_pkg.sv
// Shared types and constants for the data-bucket ingress scheduler.
// Router words are {7-bit Hamming codeword, 4-bit IP}; bucket words are {4 data bits, 4-bit IP}.
package core_db_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    SEND
  } db_arb_state_t;

  localparam int RTR_W  = 11;
  localparam int DB_W   = 8;
  localparam int IP_W   = 4;
  localparam int CW_LSB = 4;

  function automatic logic [DB_W-1:0] db_pack(input logic [DB_W-IP_W-1:0] data,
                                              input logic [IP_W-1:0]      ip);
    return {data, ip};
  endfunction

endpackage

// File: rtl/core_db_hamming_dec.sv
// Combinational Hamming(7,4) single-error corrector; double errors are miscorrected as-is.
module core_db_hamming_dec
  import core_db_pkg::*;
(
  input  logic [6:0]             code_i,
  output logic [DB_W-IP_W-1:0]   data_o,
  output logic [2:0]             syndrome_o
);

  logic [2:0] syn;
  logic [6:0] fixed;

  // Syndrome value names the 1-based position of the flipped bit.
  always_comb begin
    syn[0] = code_i[0] ^ code_i[2] ^ code_i[4] ^ code_i[6];
    syn[1] = code_i[1] ^ code_i[2] ^ code_i[5] ^ code_i[6];
    syn[2] = code_i[3] ^ code_i[4] ^ code_i[5] ^ code_i[6];
    fixed  = code_i;
    if (syn != 3'd0) begin
      fixed = code_i ^ (7'd1 << (syn - 3'd1));
    end
    data_o     = {fixed[6], fixed[5], fixed[4], fixed[2]};
    syndrome_o = syn;
  end

endmodule

// File: rtl/core_db_arbiter.sv
// Round-robin scheduler sharing one Hamming corrector and the bucket write port
// among N_PORTS router channels, with a saturating corrected-word counter.
module core_db_arbiter
  import core_db_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_PORTS-1:0]         in_valid,
  input  logic [N_PORTS*RTR_W-1:0]   in_data,
  output logic [N_PORTS-1:0]         in_ready,
  output logic                       out_valid,
  output logic [DB_W-1:0]            out_data,
  output logic [$clog2(N_PORTS)-1:0] out_port,
  output logic                       out_corr,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           corr_count,
  output logic                       busy
);

  localparam int PW = $clog2(N_PORTS);

  db_arb_state_t         state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         port_q, port_d;
  logic [RTR_W-1:0]      word_q, word_d;
  logic [DB_W-1:0]       data_q, data_d;
  logic [PW-1:0]         oport_q, oport_d;
  logic                  corr_q, corr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]         grant;
  logic [DB_W-IP_W-1:0]  dec_data;
  logic [2:0]            dec_syn;

  // Scan from last+1 upward; iterating backwards lets the nearest requester win.
  function automatic logic [PW-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                            input logic [PW-1:0]      last);
    logic [PW-1:0] pick;
    int idx;
    pick = '0;
    for (int i = N_PORTS; i >= 1; i--) begin
      idx = (int'(last) + i) % N_PORTS;
      if (req[PW'(idx)]) begin
        pick = PW'(idx);
      end
    end
    return pick;
  endfunction

  core_db_hamming_dec u_dec (
    .code_i     (word_q[RTR_W-1:CW_LSB]),
    .data_o     (dec_data),
    .syndrome_o (dec_syn)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    port_d   = port_q;
    word_d   = word_q;
    data_d   = data_q;
    oport_d  = oport_q;
    corr_d   = corr_q;
    cnt_d    = cnt_q;
    in_ready = '0;
    grant    = rr_pick(in_valid, ptr_q);
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          in_ready[grant] = 1'b1;
          word_d          = in_data[int'(grant)*RTR_W +: RTR_W];
          port_d          = grant;
          state_d         = DECODE;
        end
      end
      DECODE: begin
        data_d  = db_pack(dec_data, word_q[IP_W-1:0]);
        corr_d  = (dec_syn != 3'd0);
        oport_d = port_q;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          ptr_d   = oport_q;
          state_d = IDLE;
          if (corr_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PW'(N_PORTS - 1);
      port_q  <= '0;
      word_q  <= '0;
      data_q  <= '0;
      oport_q <= '0;
      corr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      port_q  <= port_d;
      word_q  <= word_d;
      data_q  <= data_d;
      oport_q <= oport_d;
      corr_q  <= corr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign out_data   = data_q;
  assign out_port   = oport_q;
  assign out_corr   = corr_q;
  assign corr_count = cnt_q;

endmodule

// File: tb/tb_core_db_arbiter.sv
// Bench for core_db_arbiter: a transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_core_db_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*11-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [7:0]      out_data;
  logic [PW-1:0]   out_port;
  logic            out_corr;
  logic            out_ready;
  logic [CW-1:0]   corr_count;
  logic            busy;

  core_db_arbiter #(.N_PORTS(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_port   (out_port),
    .out_corr   (out_corr),
    .out_ready  (out_ready),
    .corr_count (corr_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference decode: syndrome is the XOR of the 1-based positions of all set bits.
  function automatic int refSyndrome(input logic [6:0] c);
    int s;
    s = 0;
    for (int i = 0; i < 7; i++) if (c[i]) s = s ^ (i + 1);
    return s;
  endfunction

  function automatic logic [7:0] refData(input logic [10:0] w);
    logic [6:0] c;
    int s;
    c = w[10:4];
    s = refSyndrome(c);
    if (s != 0) c[s-1] = ~c[s-1];
    return {c[6], c[5], c[4], c[2], w[3:0]};
  endfunction

  function automatic int refPick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  typedef struct {
    int         port;
    logic [7:0] data;
    bit         corr;
    int         cyc;
  } deliv_t;

  deliv_t      dq[$];
  bit          modelLive = 1'b0;
  bit          mPending;
  int          mAge;
  logic [10:0] mWord;
  int          mPort;
  int          mPtr;
  int          mCount;
  int          mGrant;
  int          cycle = 0;

  // Transaction model: a word is pending from its accept edge until the handshake edge.
  always @(posedge clk) begin
    cycle++;
    if (reset) begin
      mPending  = 1'b0;
      mAge      = 0;
      mPtr      = N - 1;
      mCount    = 0;
      modelLive = 1'b1;
    end else if (modelLive) begin
      if (!mPending) begin
        mGrant = refPick(in_valid, mPtr);
        if (mGrant >= 0) begin
          mPending = 1'b1;
          mAge     = 1;
          mWord    = in_data[mGrant*11 +: 11];
          mPort    = mGrant;
        end
      end else if (mAge >= 2 && out_ready) begin
        dq.push_back('{port: mPort, data: refData(mWord), corr: (refSyndrome(mWord[10:4]) != 0), cyc: cycle});
        mPtr = mPort;
        if (refSyndrome(mWord[10:4]) != 0 && mCount < (1 << CW) - 1) mCount++;
        mPending = 1'b0;
      end else begin
        mAge++;
      end
    end
  end

  logic [N-1:0] expReady;
  int           cmpGrant;

  always @(negedge clk) begin
    if (modelLive) begin
      expReady = '0;
      if (!mPending) begin
        cmpGrant = refPick(in_valid, mPtr);
        if (cmpGrant >= 0) expReady[cmpGrant] = 1'b1;
      end
      checkOutput("m_in_ready", in_ready, expReady);
      checkOutput("m_out_valid", out_valid, mPending && mAge >= 2);
      checkOutput("m_busy", busy, mPending);
      checkOutput("m_corr_count", corr_count, mCount);
      if (mPending && mAge >= 2) begin
        checkOutput("m_out_data", out_data, refData(mWord));
        checkOutput("m_out_port", out_port, mPort);
        checkOutput("m_out_corr", out_corr, refSyndrome(mWord[10:4]) != 0);
      end
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic setWord(input int port, input logic [10:0] w);
    in_data[port*11 +: 11] = w;
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic rst, input logic rdy);
    in_valid  = v;
    reset     = rst;
    out_ready = rdy;
  endtask

  // One word through an idle DUT with out_ready high; ends 2 time units after the handshake edge.
  task automatic sendWord(input int port, input logic [10:0] w, input logic [7:0] eData, input logic eCorr);
    logic [N-1:0] oneHot;
    oneHot       = '0;
    oneHot[port] = 1'b1;
    setWord(port, w);
    applyStimulus(oneHot, 1'b0, 1'b1);
    #1;
    checkOutput("grant_in_ready", in_ready, oneHot);
    stepCycles(1);
    applyStimulus('0, 1'b0, 1'b1);
    stepCycles(1);
    checkOutput("send_out_valid", out_valid, 1'b1);
    checkOutput("send_out_data", out_data, eData);
    checkOutput("send_out_port", out_port, port);
    checkOutput("send_out_corr", out_corr, eCorr);
    stepCycles(1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    in_data = '0;
    applyStimulus('0, 1'b1, 1'b1);
    stepCycles(2);

    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_data", out_data, 8'h00);
    checkOutput("rst_out_port", out_port, 0);
    checkOutput("rst_out_corr", out_corr, 1'b0);
    checkOutput("rst_corr_count", corr_count, 0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_in_ready", in_ready, 4'b0000);
    applyStimulus('0, 1'b0, 1'b1);
    stepCycles(1);

    $display("[TB] clean word on port 1");
    sendWord(1, 11'h663, 8'hD3, 1'b0);
    checkOutput("clean_count", corr_count, 0);
    checkOutput("clean_model_data", dq[dq.size()-1].data, 8'hD3);
    checkOutput("clean_model_port", dq[dq.size()-1].port, 1);

    $display("[TB] single-bit errors");
    sendWord(0, 11'h763, 8'hD3, 1'b1);
    checkOutput("err_count_1", corr_count, 1);
    for (int b = 0; b < 7; b++) begin
      sendWord(b % N, 11'h663 ^ (11'h010 << b), 8'hD3, 1'b1);
    end
    checkOutput("err_count_8", corr_count, 8);

    $display("[TB] saturation");
    applyStimulus('0, 1'b1, 1'b1);
    stepCycles(1);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("sat_cleared", corr_count, 0);
    for (int k = 0; k < 17; k++) begin
      sendWord(k % N, 11'h663 ^ (11'h010 << (k % 7)), 8'hD3, 1'b1);
      if (k == 14) checkOutput("sat_at_15", corr_count, 15);
    end
    checkOutput("sat_stays_15", corr_count, 15);

    $display("[TB] round robin");
    dq.delete();
    for (int p = 0; p < N; p++) setWord(p, 11'h660 | 11'(p));
    applyStimulus(4'b1111, 1'b1, 1'b1);
    stepCycles(1);
    applyStimulus(4'b1111, 1'b0, 1'b1);
    for (int n = 0; n < 60 && dq.size() < 6; n++) stepCycles(1);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("rr_delivered", dq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      checkOutput("rr_port", dq[i].port, i % N);
      checkOutput("rr_data", dq[i].data, 8'hD0 | 8'(i % N));
      if (i > 0) checkOutput("rr_spacing", dq[i].cyc - dq[i-1].cyc, 3);
    end
    stepCycles(1);

    $display("[TB] backpressure");
    setWord(3, 11'h663 ^ 11'h010);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    stepCycles(1);
    applyStimulus(4'b0111, 1'b0, 1'b0);
    stepCycles(1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_out_valid", out_valid, 1'b1);
      checkOutput("bp_out_data", out_data, 8'hD3);
      checkOutput("bp_out_port", out_port, 3);
      checkOutput("bp_in_ready", in_ready, 4'b0000);
      stepCycles(1);
    end
    base = dq.size();
    applyStimulus('0, 1'b0, 1'b1);
    stepCycles(1);
    checkOutput("bp_delivered_once", dq.size(), base + 1);
    stepCycles(3);
    checkOutput("bp_no_repeat", dq.size(), base + 1);
    checkOutput("bp_count", corr_count, 1);

    $display("[TB] reset mid-operation");
    setWord(0, 11'h763);
    applyStimulus(4'b0001, 1'b0, 1'b1);
    stepCycles(1);
    applyStimulus('0, 1'b1, 1'b1);
    stepCycles(1);
    applyStimulus('0, 1'b0, 1'b1);
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 1'b0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_count", corr_count, 0);
    sendWord(2, 11'h663, 8'hD3, 1'b0);
    checkOutput("mid_rst_model_port", dq[dq.size()-1].port, 2);
    stepCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
